// File: rtl/watch_mode_controller.sv
// Watch mode controller: four debounced buttons drive a WATCH/ALARM/STOP mode FSM
// with a SET sub-state, alarm arming, and stopwatch run/clear control.
module watch_mode_controller #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       u_mode,
  input  logic       u_set,
  input  logic       u_op1,
  input  logic       u_op2,
  output logic       isWatch,
  output logic       isAlarm,
  output logic       isStop,
  output logic       set_active,
  output logic [1:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       alarm_en,
  output logic       sw_run,
  output logic       sw_clear
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WATCH = 2'd0,
    S_ALARM = 2'd1,
    S_STOP  = 2'd2
  } mode_t;

  // Bit order everywhere below: {op2, op1, set, mode}.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_acc;
  logic [3:0]    r_acc_d;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_evt;
  logic          w_ev_mode;
  logic          w_ev_set;
  logic          w_ev_op1;
  logic          w_ev_op2;

  assign w_raw = {u_op2, u_op1, u_set, u_mode};

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_acc[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press events: rising accepted level; only the highest-priority one survives.
  assign w_evt     = r_acc & ~r_acc_d;
  assign w_ev_mode = w_evt[0];
  assign w_ev_set  = w_evt[1] & ~w_evt[0];
  assign w_ev_op1  = w_evt[2] & ~(|w_evt[1:0]);
  assign w_ev_op2  = w_evt[3] & ~(|w_evt[2:0]);

  mode_t      r_mode, w_mode_nx;
  logic       r_set, w_set_nx;
  logic [1:0] r_field, w_field_nx;
  logic       r_alarm, w_alarm_nx;
  logic       r_run, w_run_nx;
  logic       r_inc, w_inc_nx;
  logic       r_dec, w_dec_nx;
  logic       r_clr, w_clr_nx;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_mode  <= S_WATCH;
      r_set   <= 1'b0;
      r_field <= 2'd0;
      r_alarm <= 1'b0;
      r_run   <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_mode  <= w_mode_nx;
      r_set   <= w_set_nx;
      r_field <= w_field_nx;
      r_alarm <= w_alarm_nx;
      r_run   <= w_run_nx;
      r_inc   <= w_inc_nx;
      r_dec   <= w_dec_nx;
      r_clr   <= w_clr_nx;
    end
  end

  always_comb begin
    w_mode_nx  = r_mode;
    w_set_nx   = r_set;
    w_field_nx = r_field;
    w_alarm_nx = r_alarm;
    w_run_nx   = r_run;
    w_inc_nx   = 1'b0;
    w_dec_nx   = 1'b0;
    w_clr_nx   = 1'b0;
    if (w_ev_mode) begin
      case (r_mode)
        S_WATCH: w_mode_nx = S_ALARM;
        S_ALARM: w_mode_nx = S_STOP;
        default: w_mode_nx = S_WATCH;
      endcase
      w_set_nx   = 1'b0;
      w_field_nx = 2'd0;
    end else if (w_ev_set) begin
      if (r_mode != S_STOP) begin
        if (!r_set) begin
          w_set_nx   = 1'b1;
          w_field_nx = 2'd0;
        end else if ((r_mode == S_WATCH && r_field != 2'd2) ||
                     (r_mode == S_ALARM && r_field == 2'd0)) begin
          w_field_nx = r_field + 2'd1;
        end else begin
          w_set_nx   = 1'b0;
          w_field_nx = 2'd0;
        end
      end
    end else if (w_ev_op1) begin
      if (r_set)                  w_inc_nx   = 1'b1;
      else if (r_mode == S_ALARM) w_alarm_nx = ~r_alarm;
      else if (r_mode == S_STOP)  w_run_nx   = ~r_run;
    end else if (w_ev_op2) begin
      if (r_set)                            w_dec_nx = 1'b1;
      else if (r_mode == S_STOP && !r_run)  w_clr_nx = 1'b1;
    end
  end

  assign isWatch    = (r_mode == S_WATCH);
  assign isAlarm    = (r_mode == S_ALARM);
  assign isStop     = (r_mode == S_STOP);
  assign set_active = r_set;
  assign field_sel  = r_field;
  assign inc_pulse  = r_inc;
  assign dec_pulse  = r_dec;
  assign alarm_en   = r_alarm;
  assign sw_run     = r_run;
  assign sw_clear   = r_clr;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Bench for watch_mode_controller: table of button presses with expected end states,
// hand-written latency/reset sequences, and random presses against a history-window model.
module tb_watch_mode_controller;

  localparam int D = 4;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       u_mode, u_set, u_op1, u_op2;
  logic       isWatch, isAlarm, isStop, set_active;
  logic [1:0] field_sel;
  logic       inc_pulse, dec_pulse, alarm_en, sw_run, sw_clear;

  watch_mode_controller #(.DEB_CYCLES(D)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .u_mode    (u_mode),
    .u_set     (u_set),
    .u_op1     (u_op1),
    .u_op2     (u_op2),
    .isWatch   (isWatch),
    .isAlarm   (isAlarm),
    .isStop    (isStop),
    .set_active(set_active),
    .field_sel (field_sel),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .alarm_en  (alarm_en),
    .sw_run    (sw_run),
    .sw_clear  (sw_clear)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_inc, cnt_dec, cnt_clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode as 0/1/2, button acceptance judged from a window of raw history.
  int  m_mode, m_field;
  bit  m_set, m_alarm, m_run, m_inc, m_dec, m_clr;
  bit  m_acc  [4];
  bit  m_rose [4];
  bit  hist   [4][$];

  task automatic model_reset();
    m_mode = 0; m_field = 0;
    m_set = 0; m_alarm = 0; m_run = 0; m_inc = 0; m_dec = 0; m_clr = 0;
    for (int b = 0; b < 4; b++) begin
      m_acc[b] = 0; m_rose[b] = 0; hist[b].delete();
    end
  endtask

  task automatic model_edge(input logic [3:0] raw);
    bit stable, s;
    m_inc = 0; m_dec = 0; m_clr = 0;
    if (m_rose[0]) begin
      m_mode = (m_mode + 1) % 3; m_set = 0; m_field = 0;
    end else if (m_rose[1]) begin
      if (m_mode != 2) begin
        if (!m_set) begin m_set = 1; m_field = 0; end
        else if (m_field < ((m_mode == 0) ? 2 : 1)) m_field++;
        else begin m_set = 0; m_field = 0; end
      end
    end else if (m_rose[2]) begin
      if (m_set) m_inc = 1;
      else if (m_mode == 1) m_alarm = !m_alarm;
      else if (m_mode == 2) m_run = !m_run;
    end else if (m_rose[3]) begin
      if (m_set) m_dec = 1;
      else if (m_mode == 2 && !m_run) m_clr = 1;
    end
    // A level is accepted once the D synchronized samples (raw delayed by two edges) all differ.
    for (int b = 0; b < 4; b++) begin
      hist[b].push_front(raw[b]);
      if (hist[b].size() > D + 2) void'(hist[b].pop_back());
      stable = 1;
      for (int age = 2; age <= D + 1; age++) begin
        s = (age < hist[b].size()) ? hist[b][age] : 1'b0;
        if (s == m_acc[b]) stable = 0;
      end
      m_rose[b] = stable && !m_acc[b];
      if (stable) m_acc[b] = !m_acc[b];
    end
  endtask

  function automatic logic [10:0] model_vec();
    return {m_mode == 0, m_mode == 1, m_mode == 2, m_set, 2'(m_field),
            m_inc, m_dec, m_alarm, m_run, m_clr};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {isWatch, isAlarm, isStop, set_active, field_sel,
            inc_pulse, dec_pulse, alarm_en, sw_run, sw_clear};
  endfunction

  task automatic set_btn(input logic [3:0] mask);
    {u_op2, u_op1, u_set, u_mode} = mask;
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    if (reset) model_reset();
    else model_edge({u_op2, u_op1, u_set, u_mode});
    @(negedge clk_50MHz);
    check("model", 32'(dut_vec()), 32'(model_vec()));
    check("onehot", 32'($countones({isWatch, isAlarm, isStop})), 32'd1);
    cnt_inc += int'(inc_pulse);
    cnt_dec += int'(dec_pulse);
    cnt_clr += int'(sw_clear);
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    set_btn(mask);
    repeat (hold) step();
    set_btn(4'b0000);
    repeat (gap) step();
  endtask

  task automatic assert_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_vec", 32'(dut_vec()), 32'h400);
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] btn;
    int mode; bit set; int field; bit alarm; bit run;
    int inc; int dec; int clr;
  } vec_t;

  vec_t tbl[$];
  logic [2:0] exp_onehot;

  initial begin
    set_btn(4'b0000);
    reset = 1'b1;
    #5;
    model_reset();
    check("reset_init", 32'(dut_vec()), 32'h400);
    repeat (3) step();
    reset = 1'b0;

    //               btn     mode set fld al run inc dec clr
    tbl.push_back('{4'b0001, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 2, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 0, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{4'b0100, 0, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{4'b0010, 0, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1000, 0, 1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b0010, 0, 1, 2, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 1, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1000, 1, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 1, 1, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 1, 1, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 1, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 2, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0010, 2, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 2, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b1000, 2, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0100, 2, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b1000, 2, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{4'b0100, 2, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0001, 1, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0010, 1, 1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0101, 2, 0, 0, 1, 1, 0, 0, 0});

    foreach (tbl[i]) begin
      cnt_inc = 0; cnt_dec = 0; cnt_clr = 0;
      press(tbl[i].btn, 2 * D, 2 * D);
      exp_onehot = 3'b100 >> tbl[i].mode;
      check($sformatf("tbl%0d_mode", i), 32'({isWatch, isAlarm, isStop}), 32'(exp_onehot));
      check($sformatf("tbl%0d_set", i), 32'(set_active), 32'(tbl[i].set));
      check($sformatf("tbl%0d_field", i), 32'(field_sel), 32'(tbl[i].field));
      check($sformatf("tbl%0d_alarm", i), 32'(alarm_en), 32'(tbl[i].alarm));
      check($sformatf("tbl%0d_run", i), 32'(sw_run), 32'(tbl[i].run));
      check($sformatf("tbl%0d_inc", i), 32'(cnt_inc), 32'(tbl[i].inc));
      check($sformatf("tbl%0d_dec", i), 32'(cnt_dec), 32'(tbl[i].dec));
      check($sformatf("tbl%0d_clr", i), 32'(cnt_clr), 32'(tbl[i].clr));
    end

    // In STOP with sw_run=1: a glitch one cycle short of D must be ignored.
    press(4'b0100, D - 1, 2 * D);
    check("glitch_run", 32'(sw_run), 32'd1);

    // Held from edge 0: the toggle lands exactly at edge D+2.
    set_btn(4'b0100);
    for (int k = 0; k <= D + 2; k++) begin
      step();
      if (k == D + 1) check("lat_before", 32'(sw_run), 32'd1);
      if (k == D + 2) check("lat_edge", 32'(sw_run), 32'd0);
    end
    set_btn(4'b0000);
    repeat (2 * D) step();

    // Reset during WATCH SET with u_mode held through deassertion.
    press(4'b0001, 2 * D, 2 * D);
    press(4'b0010, 2 * D, 2 * D);
    check("pre_reset_set", 32'(set_active), 32'd1);
    set_btn(4'b0001);
    assert_reset(3);
    for (int k = 0; k <= D + 2; k++) begin
      step();
      if (k == D + 1) check("held_reset_before", 32'(isAlarm), 32'd0);
      if (k == D + 2) check("held_reset_edge", 32'(isAlarm), 32'd1);
    end
    set_btn(4'b0000);
    repeat (2 * D) step();

    // Random presses; the per-cycle model comparison does the checking.
    repeat (250) begin
      if ($urandom_range(0, 39) == 0) begin
        assert_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 2) == 0) begin
        press(4'($urandom_range(0, 15)), $urandom_range(1, 3 * D), $urandom_range(1, 3 * D));
      end else begin
        press(4'(1 << $urandom_range(0, 3)), $urandom_range(D - 2, 3 * D),
              $urandom_range(D, 3 * D));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
